lm70_sample_scheduler: RTL

LM70_SAMPLE_SCHEDULER -- requirements
Module: lm70_sample_scheduler

---
 rtl/lm70_pkg.sv | 9 +
 rtl/lm70_spi_shifter.sv | 36 +++
 rtl/lm70_sample_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lm70_pkg.sv
// lm70_pkg: shared states and frame constants for the LM70 sample scheduler.
package lm70_pkg;
    localparam int FRAME_BITS = 16;
    localparam int SETUP_CLKS = 2;
    localparam int HOLD_CLKS = 2;
    localparam int TEMP_W = 11;
    localparam logic [4:0] STATUS_ONES = 5'b11111;
    typedef enum logic [2:0] {IDLE, WAIT, SETUP, SHIFT, HOLD} state_t;
endpackage

// File: rtl/lm70_spi_shifter.sv
// lm70_spi_shifter: drives sck for one 16-bit frame, shifts sio in MSB-first, flags done.
module lm70_spi_shifter
    import lm70_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sio,
    output logic                  sck,
    output logic                  done,
    output logic [FRAME_BITS-1:0] data
);
    localparam int CW = $clog2(2 * FRAME_BITS);
    logic          active;
    logic [CW-1:0] cnt;
    assign done = active && cnt == CW'(2 * FRAME_BITS - 1);
    // sio is captured on the clock that raises sck, so it was set up during the low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            sck    <= 1'b0;
            data   <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(1);
            sck    <= 1'b1;
            data   <= {data[FRAME_BITS-2:0], sio};
        end else if (active) begin
            active <= !done;
            cnt    <= cnt + 1'b1;
            sck    <= ~sck;
            if (!sck) data <= {data[FRAME_BITS-2:0], sio};
        end
    end
endmodule

// File: rtl/lm70_sample_scheduler.sv
// lm70_sample_scheduler: periodic LM70 reader with valid/ready output; define TEMP_AVG_EN for a 4-sample moving average.
module lm70_sample_scheduler
    import lm70_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [7:0]        period,
    input  logic [TEMP_W-1:0] thresh,
    input  logic              sio,
    output logic              cs_n,
    output logic              sck,
    output logic [TEMP_W-1:0] temp,
    output logic              temp_valid,
    input  logic              temp_ready,
    output logic              alarm,
    output logic              frame_err,
    output logic              overrun
);
    state_t                  state;
    logic [7:0]              cnt;
    logic [7:0]              wait_last;
    logic                    start;
    logic                    done;
    logic [FRAME_BITS-1:0]   data;
    logic [TEMP_W-1:0]       raw;
    logic [TEMP_W-1:0]       temp_new;
    logic                    good;
    logic                    pub;
    assign wait_last = (period == 8'd0) ? 8'd0 : period - 8'd1;
    assign start     = state == SETUP && cnt == 8'(SETUP_CLKS - 1);
    assign raw       = data[FRAME_BITS-1:5];
    assign good      = data[4:0] == STATUS_ONES;
    assign pub       = done && good;

    lm70_spi_shifter u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sio   (sio),
        .sck   (sck),
        .done  (done),
        .data  (data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cs_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (!enable) state <= IDLE;
                    else if (cnt == wait_last) begin
                        state <= SETUP;
                        cnt   <= '0;
                        cs_n  <= 1'b0;
                    end else cnt <= cnt + 8'd1;
                SETUP: if (start) begin
                    state <= SHIFT;
                    cnt   <= '0;
                end else cnt <= cnt + 8'd1;
                SHIFT: if (done) begin
                    state <= HOLD;
                    cs_n  <= 1'b1;
                end
                HOLD: if (cnt == 8'(HOLD_CLKS - 1)) begin
                    state <= enable ? WAIT : IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + 8'd1;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TEMP_AVG_EN
    localparam int SW = TEMP_W + 2;
    logic [TEMP_W-1:0] win [3];
    logic              filled;
    logic signed [SW-1:0] sum;
    assign sum = SW'($signed(raw)) + SW'($signed(win[0])) + SW'($signed(win[1])) + SW'($signed(win[2]));
    // the first good sample after reset stands in for the whole window
    assign temp_new = filled ? TEMP_W'(sum >>> 2) : raw;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win[0] <= '0;
            win[1] <= '0;
            win[2] <= '0;
            filled <= 1'b0;
        end else if (pub) begin
            win[0] <= raw;
            win[1] <= filled ? win[0] : raw;
            win[2] <= filled ? win[1] : raw;
            filled <= 1'b1;
        end
    end
`else
    assign temp_new = raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp       <= '0;
            temp_valid <= 1'b0;
            alarm      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= done && !good;
            if (pub) begin
                temp       <= temp_new;
                temp_valid <= 1'b1;
                alarm      <= $signed(temp_new) > $signed(thresh);
                if (temp_valid && !temp_ready) overrun <= 1'b1;
            end else if (temp_ready) temp_valid <= 1'b0;
        end
    end
endmodule
